int_mul_sched: RTL and testbench
================================

// Module: int_mul_sched
// PURPOSE
//   Round-robin scheduler sharing one iterative int_mul unit among NUM_REQ requesters.
//   Accepts one request, issues it and holds operands stable for the whole multiply.
//   Returns the product to the granted requester over a valid/ready response port.
//   Sits between the ALU issue ports and the single int_mul instance.
// PARAMETERS
//   NUM_REQ        4   requester count (2..8)
//   TIMEOUT_CYCLES 40  WAIT-state watchdog limit; used only with INT_MUL_SCHED_TIMEOUT_EN
// PORTS
//   i_clk          in   1         clock, rising edge
//   i_rst          in   1         synchronous reset, active-high
//   i_req_valid    in   NUM_REQ   per-requester request valid
//   o_req_ready    out  NUM_REQ   one-hot accept; valid&ready = request taken
//   i_req_a        in   NUM_REQ*32  operand A, requester k at [32k+31:32k]
//   i_req_b        in   NUM_REQ*32  operand B, same packing
//   o_rsp_valid    out  NUM_REQ   one-hot response valid
//   i_rsp_ready    in   NUM_REQ   per-requester response ready
//   o_rsp_result   out  32        product, shared by all requesters
//   o_rsp_err      out  1         response is a timeout (result 0)
//   o_busy         out  1         state != IDLE
//   o_mul_valid    out  1         int_mul start pulse
//   o_mul_a        out  32        int_mul operand A
//   o_mul_b        out  32        int_mul operand B
//   i_mul_valid    in   1         int_mul done
//   i_mul_result   in   32        int_mul product
//   o_mul_rst_n    out  1         int_mul active-low reset
// BEHAVIOUR
//   Reset: state IDLE, rr_ptr 0; all outputs 0 except o_mul_rst_n.
//     Operand and result registers are cleared.
//   o_mul_rst_n = ~i_rst (combinational), plus the timeout pulse below.
//     A reset mid-operation also resets int_mul, so no stale computation survives.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: o_req_ready is one-hot on the first valid requester, searching from rr_ptr
//     upward modulo NUM_REQ; combinational.
//     On accept: latch a/b/grant into registers, go to ISSUE.
//     No valid request: stay in IDLE, o_req_ready = 0.
//   ISSUE: o_mul_valid = 1 for exactly one cycle, then WAIT.
//   WAIT: o_mul_a/o_mul_b stay equal to the latched operands from ISSUE until leaving RESP.
//     int_mul reads A on every iteration, so these must not change.
//     On i_mul_valid: capture i_mul_result, go to RESP.
//   RESP: o_rsp_valid[grant] = 1; o_rsp_result held stable.
//     On i_rsp_ready[grant]: rr_ptr = (grant+1) mod NUM_REQ, go to IDLE.
//     No back-to-back issue: next accept is no earlier than the following cycle.
//   i_mul_valid outside WAIT is ignored.
//   o_mul_valid is never asserted while int_mul is busy.
//   Latency with int_mul: accept at cycle 0, ISSUE at cycle 1, i_mul_valid at cycle 34,
//     o_rsp_valid at cycle 35.
//   Products are passed through unmodified; the scheduler does no sign handling.
// CONFIGURATION
//   INT_MUL_SCHED_TIMEOUT_EN defined:
//     A WAIT counter is cleared on WAIT entry.
//     When it reaches TIMEOUT_CYCLES without i_mul_valid:
//       o_mul_rst_n driven 0 for one cycle;
//       go to RESP with o_rsp_result = 0, o_rsp_err = 1.
//     o_rsp_err clears on the response handshake.
//   Not defined: no counter; WAIT lasts indefinitely; o_rsp_err tied to 0.
// TESTING
//   T1 req0 a=7 b=6 at cycle 0 -> o_mul_valid at cycle 1 with a=7/b=6;
//      o_rsp_valid=0001, result 42 at cycle 35.
//   T2 all four requesters valid from reset -> served in order 0,1,2,3.
//      Then, with req0 and req2 valid after serving 1: req2 is served before req0.
//   T3 i_rsp_ready low for 10 cycles in RESP -> o_rsp_valid and result stay stable,
//      o_req_ready=0, o_mul_valid=0; accept resumes the cycle after the handshake.
//   T4 i_rst pulsed at cycle 20 of WAIT -> next cycle all outputs are at reset values.
//      Then a new request a=-3 b=5 returns {1, 31'd15} at cycle 35.
//   T5 stray i_mul_valid in IDLE -> no o_rsp_valid, state stays IDLE.
//   T6 (macro defined) stub int_mul never completes -> o_mul_rst_n low for 1 cycle;
//      o_rsp_valid with err=1, result 0.
//      Without the macro: no response after 1000 cycles.

Source files
------------

// File: rtl/int_mul_sched.sv
// Round-robin scheduler that shares one iterative int_mul among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining INT_MUL_SCHED_TIMEOUT_EN.
module int_mul_sched #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [NUM_REQ*32-1:0]   i_req_a,
    input  logic [NUM_REQ*32-1:0]   i_req_b,
    output logic [NUM_REQ-1:0]      o_rsp_valid,
    input  logic [NUM_REQ-1:0]      i_rsp_ready,
    output logic [31:0]             o_rsp_result,
    output logic                    o_rsp_err,
    output logic                    o_busy,
    output logic                    o_mul_valid,
    output logic [31:0]             o_mul_a,
    output logic [31:0]             o_mul_b,
    input  logic                    i_mul_valid,
    input  logic [31:0]             i_mul_result,
    output logic                    o_mul_rst_n
);

    localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("int_mul_sched: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_grant;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [31:0]     r_result;
    logic [PW-1:0]   w_pick_idx;
    logic [PW-1:0]   w_cand;
    logic            w_pick_found;
    logic            w_accept;
    logic            w_mul_done;
    logic            w_rsp_done;
    logic            w_timeout;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        return PW'((s >= NUM_REQ) ? (s - NUM_REQ) : s);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = {NUM_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = r_rr_ptr;
        w_cand       = r_rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = wrap_inc(r_rr_ptr, i);
            if (i_req_valid[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand;
            end else begin
                w_pick_found = w_pick_found;
                w_pick_idx   = w_pick_idx;
            end
        end
    end

    assign w_accept   = (r_state == S_IDLE) && w_pick_found && !i_rst;
    assign w_mul_done = (r_state == S_WAIT) && i_mul_valid;
    assign w_rsp_done = (r_state == S_RESP) && i_rsp_ready[r_grant];

`ifdef INT_MUL_SCHED_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic        r_err;
    logic        r_tmo_pulse;

    assign w_timeout = (r_state == S_WAIT) && !i_mul_valid
                       && (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts WAIT cycles, raises error flag and a one-cycle int_mul reset on expiry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt  <= 16'd0;
            r_err       <= 1'b0;
            r_tmo_pulse <= 1'b0;
        end else begin
            r_wait_cnt  <= (r_state == S_WAIT) ? (r_wait_cnt + 16'd1) : 16'd0;
            r_tmo_pulse <= w_timeout;
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (w_rsp_done) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign o_rsp_err   = r_err;
    assign o_mul_rst_n = ~i_rst & ~r_tmo_pulse;
`else
    assign w_timeout   = 1'b0;
    assign o_rsp_err   = 1'b0;
    assign o_mul_rst_n = ~i_rst;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = (w_mul_done || w_timeout) ? S_RESP : S_WAIT;
            S_RESP:  w_next = w_rsp_done ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operands stay frozen from accept until the next accept, so int_mul sees stable A/B.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_result <= 32'd0;
            r_grant  <= {PW{1'b0}};
            r_rr_ptr <= {PW{1'b0}};
        end else begin
            if (w_accept) begin
                r_a     <= i_req_a[32*w_pick_idx +: 32];
                r_b     <= i_req_b[32*w_pick_idx +: 32];
                r_grant <= w_pick_idx;
            end else begin
                r_a     <= r_a;
                r_b     <= r_b;
                r_grant <= r_grant;
            end
            if (w_mul_done) begin
                r_result <= i_mul_result;
            end else if (w_timeout) begin
                r_result <= 32'd0;
            end else begin
                r_result <= r_result;
            end
            if (w_rsp_done) begin
                r_rr_ptr <= wrap_inc(r_grant, 1);
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
        end
    end

    // Output decode.
    always_comb begin
        o_req_ready = {NUM_REQ{1'b0}};
        o_rsp_valid = {NUM_REQ{1'b0}};
        o_mul_valid = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = w_accept ? onehot(w_pick_idx) : {NUM_REQ{1'b0}};
            end
            S_ISSUE: begin
                o_mul_valid = 1'b1;
                o_busy      = 1'b1;
            end
            S_WAIT: begin
                o_busy      = 1'b1;
            end
            S_RESP: begin
                o_rsp_valid = onehot(r_grant);
                o_busy      = 1'b1;
            end
            default: begin
                o_busy      = 1'b0;
            end
        endcase
    end

    assign o_mul_a      = r_a;
    assign o_mul_b      = r_b;
    assign o_rsp_result = r_result;

endmodule

// File: tb/tb_int_mul_sched.sv
// Self-checking bench for int_mul_sched with a sign-magnitude iterative int_mul model
// (start at cycle 1, done pulse at cycle 34) and a response scoreboard.
module tb_int_mul_sched;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*32-1:0]   req_a, req_b;
    logic [31:0]       rsp_result, mul_a, mul_b, mul_result;
    logic              rsp_err, busy, mul_valid_o, mul_valid_i, mul_rst_n;

    logic              m_busy = 1'b0;
    logic              m_valid = 1'b0;
    logic              m_hang = 1'b0;
    logic              stray = 1'b0;
    int                m_cnt = 0;
    logic [31:0]       m_res = 32'd0;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [N-1:0] who;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  res;
        logic         err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    int_mul_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(40)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_result(rsp_result), .o_rsp_err(rsp_err), .o_busy(busy),
        .o_mul_valid(mul_valid_o), .o_mul_a(mul_a), .o_mul_b(mul_b),
        .i_mul_valid(mul_valid_i), .i_mul_result(mul_result), .o_mul_rst_n(mul_rst_n)
    );

    function automatic logic [31:0] sm_mul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        logic [63:0] p;
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        p  = ma * mb;
        return {a[31] ^ b[31], p[30:0]};
    endfunction

    // int_mul model: start sampled at cycle 1, done pulse driven in cycle 34.
    always @(posedge clk) begin
        m_valid <= 1'b0;
        if (!mul_rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (mul_valid_o && !m_hang) begin
            m_busy <= 1'b1;
            m_cnt  <= 31;
            m_res  <= sm_mul(mul_a, mul_b);
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_valid <= 1'b1;
                m_busy  <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign mul_valid_i = m_valid | stray;
    assign mul_result  = m_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
        req_a[32*k +: 32] = a;
        req_b[32*k +: 32] = b;
        req_valid[k]      = 1'b1;
    endtask

    // Wait for acceptance of requester k, push the expected response, check the issue cycle.
    task automatic issue(input string tag, input int k, input logic [31:0] exp_res, input logic exp_err);
        int n;
        exp_t e;
        n = 0;
        #1;
        while (req_ready == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready"}, 32'(req_ready), 32'(1 << k));
        e.who = N'(1 << k);
        e.a   = req_a[32*k +: 32];
        e.b   = req_b[32*k +: 32];
        e.res = exp_res;
        e.err = exp_err;
        sb.push_back(e);
        @(negedge clk);
        req_valid[k] = 1'b0;
        chk({tag, " mul_valid"}, 32'(mul_valid_o), 32'd1);
        chk({tag, " mul_a"}, mul_a, e.a);
        chk({tag, " mul_b"}, mul_b, e.b);
    endtask

    // Called in cycle 1; waits for the response, checks latency 35, optionally stalls, handshakes.
    task automatic wait_rsp(input string tag, input int hold);
        int n;
        exp_t e;
        n = 1;
        while (rsp_valid == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd35);
        e = sb.pop_front();
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(e.who));
        chk({tag, " result"}, rsp_result, e.res);
        chk({tag, " err"}, 32'(rsp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, 32'(rsp_valid), 32'(e.who));
            chk({tag, " hold result"}, rsp_result, e.res);
            chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
            chk({tag, " hold mul_valid"}, 32'(mul_valid_o), 32'd0);
            chk({tag, " hold mul_a"}, mul_a, e.a);
        end
        rsp_ready = e.who;
        @(negedge clk);
        rsp_ready = '0;
        chk({tag, " idle after rsp"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int   n;
        int   cnt;
        exp_t e;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(negedge clk);
        chk("rst mul_rst_n", 32'(mul_rst_n), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst mul_valid", 32'(mul_valid_o), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst mul_rst_n", 32'(mul_rst_n), 32'd1);
        chk("post-rst result", rsp_result, 32'd0);
        chk("post-rst err", 32'(rsp_err), 32'd0);
        chk("post-rst mul_a", mul_a, 32'd0);
        chk("post-rst mul_b", mul_b, 32'd0);

        // T5: stray done pulse in IDLE is ignored
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("T5 rsp_valid", 32'(rsp_valid), 32'd0);
        chk("T5 busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("T5 rsp_valid later", 32'(rsp_valid), 32'd0);
        chk("T5 busy later", 32'(busy), 32'd0);

        // T1: basic multiply
        set_req(0, 32'd7, 32'd6);
        issue("T1", 0, 32'd42, 1'b0);
        wait_rsp("T1", 0);

        // T3: response stall, with a pending request that must wait
        set_req(1, 32'd100, 32'd3);
        issue("T3", 1, 32'd300, 1'b0);
        set_req(2, 32'd9, 32'd9);
        wait_rsp("T3", 10);
        chk("T3 resume ready", 32'(req_ready), 32'b0100);
        issue("T3b", 2, 32'd81, 1'b0);
        wait_rsp("T3b", 0);

        // T2: all requesters valid from reset
        rst = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, 32'(k + 2), 32'(k + 11));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            issue("T2 order", k, 32'((k + 2) * (k + 11)), 1'b0);
            wait_rsp("T2 order", 0);
        end
        set_req(1, 32'd4, 32'd5);
        issue("T2 r1", 1, 32'd20, 1'b0);
        wait_rsp("T2 r1", 0);
        set_req(0, 32'd3, 32'd3);
        set_req(2, 32'd8, 32'd2);
        issue("T2 r2 first", 2, 32'd16, 1'b0);
        wait_rsp("T2 r2 first", 0);
        issue("T2 r0 next", 0, 32'd9, 1'b0);
        wait_rsp("T2 r0 next", 0);

        // T4: reset in the middle of WAIT, then a signed request
        set_req(0, 32'd1, 32'd2);
        #1;
        chk("T4 ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (21) @(negedge clk);
        chk("T4 in wait", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("T4 mul_rst_n low", 32'(mul_rst_n), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("T4 req_ready", 32'(req_ready), 32'd0);
        chk("T4 rsp_valid", 32'(rsp_valid), 32'd0);
        chk("T4 result", rsp_result, 32'd0);
        chk("T4 err", 32'(rsp_err), 32'd0);
        chk("T4 busy", 32'(busy), 32'd0);
        chk("T4 mul_valid", 32'(mul_valid_o), 32'd0);
        chk("T4 mul_a", mul_a, 32'd0);
        chk("T4 mul_b", mul_b, 32'd0);
        chk("T4 mul_rst_n", 32'(mul_rst_n), 32'd1);
        set_req(0, 32'hFFFF_FFFD, 32'd5);
        issue("T4 signed", 0, 32'h8000_000F, 1'b0);
        wait_rsp("T4 signed", 0);

        // T6: int_mul never completes
        m_hang = 1'b1;
        set_req(1, 32'd5, 32'd5);
        issue("T6", 1, 32'd0, 1'b1);
`ifdef INT_MUL_SCHED_TIMEOUT_EN
        n = 0;
        while (mul_rst_n && n < 200) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        chk("T6 mul_rst_n pulse", 32'(mul_rst_n), 32'd0);
        chk("T6 rsp_valid", 32'(rsp_valid), 32'(e.who));
        chk("T6 result", rsp_result, e.res);
        chk("T6 err", 32'(rsp_err), 32'(e.err));
        @(negedge clk);
        chk("T6 mul_rst_n back", 32'(mul_rst_n), 32'd1);
        chk("T6 err held", 32'(rsp_err), 32'd1);
        rsp_ready = e.who;
        @(negedge clk);
        rsp_ready = '0;
        chk("T6 err cleared", 32'(rsp_err), 32'd0);
        chk("T6 idle", 32'(busy), 32'd0);
`else
        sb.delete();
        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (rsp_valid != '0 || !mul_rst_n) cnt++;
        end
        chk("T6 no response", 32'(cnt), 32'd0);
        chk("T6 still busy", 32'(busy), 32'd1);
        chk("T6 err", 32'(rsp_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("T6 idle after rst", 32'(busy), 32'd0);
`endif
        m_hang = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
